// File: rtl/mcu_bram_sequencer.sv
// Global sequencer for a bank of local BRAM streaming FSMs.
// Latches one job's geometry, broadcasts the shared global state
// (IDL -> STR -> OPE -> END/ERR -> IDL), collects per-reader completion
// and error levels, and aborts stalled runs with a cycle watchdog.
module mcu_bram_sequencer #(
  parameter int NUM_LOCAL        = 4,
  parameter int ADDR_WIDTH       = 32,
  parameter int INTER_ITER_WIDTH = 32,
  parameter int INTRA_ITER_WIDTH = 32,
  parameter int TIMEOUT_WIDTH    = 24,
  parameter int GLO_FSM_WIDTH    = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_WIDTH:0]         cfg_addr_max,
  input  logic [INTER_ITER_WIDTH-1:0] cfg_inter_max,
  input  logic [INTRA_ITER_WIDTH-1:0] cfg_intra_max,
  input  logic [TIMEOUT_WIDTH-1:0]    cfg_timeout,
  output logic [GLO_FSM_WIDTH-1:0]    glo_fsm_state,
  output logic [ADDR_WIDTH:0]         addr_counter_max,
  output logic [INTER_ITER_WIDTH-1:0] inter_counter_max,
  output logic [INTRA_ITER_WIDTH-1:0] intra_counter_max,
  input  logic [NUM_LOCAL-1:0]        loc_tlast_transmitted,
  input  logic [NUM_LOCAL-1:0]        loc_error,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [1:0]                  err_cause,
  output logic [NUM_LOCAL-1:0]        err_mask
);

  // Global state encodings shared with the local reader FSMs.
  typedef enum logic [GLO_FSM_WIDTH-1:0] {
    GLO_FSM_IDL = GLO_FSM_WIDTH'(3'd0),
    GLO_FSM_STR = GLO_FSM_WIDTH'(3'd1),
    GLO_FSM_OPE = GLO_FSM_WIDTH'(3'd2),
    GLO_FSM_END = GLO_FSM_WIDTH'(3'd3),
    GLO_FSM_ERR = GLO_FSM_WIDTH'(3'd4)
  } glo_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LOCAL   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam logic [NUM_LOCAL-1:0]     MASK_ALL   = {NUM_LOCAL{1'b1}};
  localparam logic [NUM_LOCAL-1:0]     MASK_NONE  = {NUM_LOCAL{1'b0}};
  localparam logic [TIMEOUT_WIDTH-1:0] WD_ZERO    = {TIMEOUT_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH:0]      ADDR_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [INTER_ITER_WIDTH-1:0] INTER_ZERO = {INTER_ITER_WIDTH{1'b0}};
  localparam logic [INTRA_ITER_WIDTH-1:0] INTRA_ZERO = {INTRA_ITER_WIDTH{1'b0}};

  glo_state_e                 state_r;
  logic [NUM_LOCAL-1:0]       done_mask_r;
  logic [TIMEOUT_WIDTH-1:0]   wd_cnt_r;
  logic [TIMEOUT_WIDTH-1:0]   timeout_r;

  logic                       any_err_s;
  logic                       cfg_zero_s;
  logic [NUM_LOCAL-1:0]       done_mask_next_s;
  logic                       all_done_s;
  logic [TIMEOUT_WIDTH-1:0]   wd_inc_s;
  logic                       wd_hit_s;

  assign glo_fsm_state = state_r;

  // Event decode: errors, zero geometry, sticky completion and watchdog expiry.
  // The watchdog compares the incremented count so ERR lands exactly
  // timeout cycles after OPE entry.
  always_comb begin
    any_err_s        = |loc_error;
    cfg_zero_s       = (addr_counter_max == ADDR_ZERO) || (inter_counter_max == INTER_ZERO);
    done_mask_next_s = done_mask_r | loc_tlast_transmitted;
    all_done_s       = (done_mask_next_s == MASK_ALL);
    wd_inc_s         = wd_cnt_r + TIMEOUT_WIDTH'(1'b1);
    if (timeout_r != WD_ZERO) begin
      wd_hit_s = (wd_inc_s == timeout_r);
    end else begin
      wd_hit_s = 1'b0;
    end
  end

  // Global FSM with registered status, pulses, latched geometry and abort record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r           <= GLO_FSM_IDL;
      addr_counter_max  <= ADDR_ZERO;
      inter_counter_max <= INTER_ZERO;
      intra_counter_max <= INTRA_ZERO;
      timeout_r         <= WD_ZERO;
      done_mask_r       <= MASK_NONE;
      wd_cnt_r          <= WD_ZERO;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      err_cause         <= ERR_NONE;
      err_mask          <= MASK_NONE;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_r)
        GLO_FSM_IDL: begin
          if (start) begin
            addr_counter_max  <= cfg_addr_max;
            inter_counter_max <= cfg_inter_max;
            intra_counter_max <= cfg_intra_max;
            timeout_r         <= cfg_timeout;
            err_cause         <= ERR_NONE;
            err_mask          <= MASK_NONE;
            done_mask_r       <= MASK_NONE;
            wd_cnt_r          <= WD_ZERO;
            state_r           <= GLO_FSM_STR;
            busy              <= 1'b1;
          end else begin
            state_r <= GLO_FSM_IDL;
            busy    <= 1'b0;
          end
        end

        GLO_FSM_STR: begin
          // Zero geometry is a local error too: the readers flag it themselves.
          if (any_err_s || cfg_zero_s) begin
            state_r   <= GLO_FSM_ERR;
            err_cause <= ERR_LOCAL;
            err_mask  <= loc_error;
          end else begin
            state_r  <= GLO_FSM_OPE;
            wd_cnt_r <= WD_ZERO;
          end
          busy <= 1'b1;
        end

        GLO_FSM_OPE: begin
          done_mask_r <= done_mask_next_s;
          wd_cnt_r    <= wd_inc_s;
          // Priority: local error, then watchdog, then completion.
          if (any_err_s) begin
            state_r   <= GLO_FSM_ERR;
            err_cause <= ERR_LOCAL;
            err_mask  <= loc_error;
          end else if (wd_hit_s) begin
            state_r   <= GLO_FSM_ERR;
            err_cause <= ERR_TIMEOUT;
            err_mask  <= MASK_NONE;
          end else if (all_done_s) begin
            state_r <= GLO_FSM_END;
          end else begin
            state_r <= GLO_FSM_OPE;
          end
          busy <= 1'b1;
        end

        GLO_FSM_END: begin
          state_r <= GLO_FSM_IDL;
          busy    <= 1'b0;
          done    <= 1'b1;
        end

        GLO_FSM_ERR: begin
          state_r <= GLO_FSM_IDL;
          busy    <= 1'b0;
          err     <= 1'b1;
        end

        default: begin
          state_r <= GLO_FSM_IDL;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_bram_sequencer.sv
// Directed scoreboard bench for mcu_bram_sequencer.
// Stimulus pushes expected done/err pulses (cycle, cause, mask) into a queue;
// a monitor pops and compares whenever a pulse appears.
module tb_mcu_bram_sequencer;

  localparam int NL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [32:0] cfg_addr_max = 33'd0;
  logic [31:0] cfg_inter_max = 32'd0;
  logic [31:0] cfg_intra_max = 32'd0;
  logic [23:0] cfg_timeout = 24'd0;
  logic [2:0]  glo_fsm_state;
  logic [32:0] addr_counter_max;
  logic [31:0] inter_counter_max;
  logic [31:0] intra_counter_max;
  logic [NL-1:0] loc_tlast_transmitted = 4'd0;
  logic [NL-1:0] loc_error = 4'd0;
  logic        busy, done, err;
  logic [1:0]  err_cause;
  logic [NL-1:0] err_mask;

  mcu_bram_sequencer #(.NUM_LOCAL(NL)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_addr_max(cfg_addr_max), .cfg_inter_max(cfg_inter_max),
    .cfg_intra_max(cfg_intra_max), .cfg_timeout(cfg_timeout),
    .glo_fsm_state(glo_fsm_state), .addr_counter_max(addr_counter_max),
    .inter_counter_max(inter_counter_max), .intra_counter_max(intra_counter_max),
    .loc_tlast_transmitted(loc_tlast_transmitted), .loc_error(loc_error),
    .busy(busy), .done(done), .err(err), .err_cause(err_cause), .err_mask(err_mask)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    int         at;
    logic [1:0] cause;
    logic [3:0] mask;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit is_err, input int at, input int cause, input int mask);
    exp_t e;
    e.is_err = is_err;
    e.at     = at;
    e.cause  = 2'(cause);
    e.mask   = 4'(mask);
    sb_q.push_back(e);
  endtask

  task automatic set_cfg(input longint a, input longint ie, input longint ia, input longint t);
    cfg_addr_max  = 33'(a);
    cfg_inter_max = 32'(ie);
    cfg_intra_max = 32'(ia);
    cfg_timeout   = 24'(t);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every done/err pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (done || err)) begin
      if (sb_q.size() == 0) begin
        total = total + 1;
        bad = bad + 1;
        $display("FAIL sb_unexpected: got done=%0b err=%0b expected no pulse (cycle %0d)", done, err, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_kind", 64'({done, err}), 64'({~e.is_err, e.is_err}));
        chk("sb_cycle", 64'(cyc), 64'(e.at));
        chk("sb_cause", 64'(err_cause), 64'(e.cause));
        chk("sb_mask", 64'(err_mask), 64'(e.mask));
      end
    end
  end

  // Global run bound.
  initial begin
    #60000;
    $display("FAIL run_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "bench time limit");
  end

  int s;
  int s2;

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_state", 64'(glo_fsm_state), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_cause", 64'(err_cause), 64'(0));
    chk("rst_mask", 64'(err_mask), 64'(0));
    chk("rst_addr", 64'(addr_counter_max), 64'(0));
    chk("rst_inter", 64'(inter_counter_max), 64'(0));
    chk("rst_intra", 64'(intra_counter_max), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // T1: normal job, staggered completions 20,22,25,25
    s = cyc;
    set_cfg(8, 2, 1, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t1_str", 64'(glo_fsm_state), 64'(1));
    chk("t1_addr", 64'(addr_counter_max), 64'(8));
    chk("t1_inter", 64'(inter_counter_max), 64'(2));
    chk("t1_intra", 64'(intra_counter_max), 64'(1));
    chk("t1_busy", 64'(busy), 64'(1));
    @(negedge clk);
    chk("t1_ope", 64'(glo_fsm_state), 64'(2));
    push(1'b0, s + 27, 0, 0);
    wait_to(s + 20); loc_tlast_transmitted = 4'b0001;
    wait_to(s + 22); loc_tlast_transmitted = 4'b0011;
    wait_to(s + 25); loc_tlast_transmitted = 4'b1111;
    wait_to(s + 26);
    chk("t1_end", 64'(glo_fsm_state), 64'(3));
    wait_to(s + 27);
    chk("t1_idle", 64'(glo_fsm_state), 64'(0));
    chk("t1_busy_low", 64'(busy), 64'(0));
    loc_tlast_transmitted = 4'b0000;
    wait_to(s + 30);

    // T2: error on bit 2 with bit 1 completing in the same cycle
    s = cyc;
    set_cfg(4, 1, 1, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    push(1'b1, s + 14, 1, 4'b0100);
    wait_to(s + 12);
    loc_error = 4'b0100;
    loc_tlast_transmitted = 4'b0010;
    wait_to(s + 13);
    chk("t2_errstate", 64'(glo_fsm_state), 64'(4));
    wait_to(s + 14);
    loc_error = 4'b0000;
    loc_tlast_transmitted = 4'b0000;
    chk("t2_idle", 64'(glo_fsm_state), 64'(0));
    wait_to(s + 16);
    chk("t2_mask_hold", 64'(err_mask), 64'(4'b0100));
    chk("t2_cause_hold", 64'(err_cause), 64'(1));

    // T3: watchdog 50 cycles after OPE entry
    s = cyc;
    set_cfg(8, 2, 1, 50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    push(1'b1, s + 53, 2, 0);
    wait_to(s + 51);
    chk("t3_still_ope", 64'(glo_fsm_state), 64'(2));
    wait_to(s + 52);
    chk("t3_errstate", 64'(glo_fsm_state), 64'(4));
    wait_to(s + 55);

    // T3b: watchdog disabled, stays in OPE for 1000 cycles
    s = cyc;
    set_cfg(8, 2, 1, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t3b_cause_clr", 64'(err_cause), 64'(0));
    wait_to(s + 1002);
    chk("t3b_ope_1000", 64'(glo_fsm_state), 64'(2));
    loc_tlast_transmitted = 4'b1111;
    push(1'b0, s + 1004, 0, 0);
    wait_to(s + 1004);
    loc_tlast_transmitted = 4'b0000;
    wait_to(s + 1006);

    // T4: zero geometry aborts from STR, then back-to-back restart on err cycle
    s = cyc;
    set_cfg(0, 1, 1, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    loc_error = 4'hF;
    chk("t4_str", 64'(glo_fsm_state), 64'(1));
    push(1'b1, s + 3, 1, 4'hF);
    wait_to(s + 2);
    chk("t4_errstate", 64'(glo_fsm_state), 64'(4));
    wait_to(s + 3);
    loc_error = 4'h0;
    set_cfg(8, 2, 1, 0);
    start = 1'b1;
    s2 = s + 3;
    @(negedge clk);
    start = 1'b0;
    chk("t4_restart_str", 64'(glo_fsm_state), 64'(1));
    chk("t4_cause_clr", 64'(err_cause), 64'(0));
    chk("t4_mask_clr", 64'(err_mask), 64'(0));
    push(1'b0, s2 + 7, 0, 0);
    wait_to(s2 + 5); loc_tlast_transmitted = 4'hF;
    wait_to(s2 + 7); loc_tlast_transmitted = 4'h0;
    wait_to(s2 + 9);

    // T5: start held and cfg changed mid-job; back-to-back start on done cycle
    s = cyc;
    set_cfg(16, 3, 2, 0);
    start = 1'b1;
    wait_to(s + 5);
    set_cfg(99, 7, 5, 0);
    wait_to(s + 8);
    chk("t5_ope", 64'(glo_fsm_state), 64'(2));
    chk("t5_addr_kept", 64'(addr_counter_max), 64'(16));
    chk("t5_inter_kept", 64'(inter_counter_max), 64'(3));
    chk("t5_intra_kept", 64'(intra_counter_max), 64'(2));
    wait_to(s + 10);
    loc_tlast_transmitted = 4'hF;
    push(1'b0, s + 12, 0, 0);
    push(1'b0, s + 16, 0, 0);
    wait_to(s + 13);
    start = 1'b0;
    chk("t5_b2b_str", 64'(glo_fsm_state), 64'(1));
    chk("t5_new_addr", 64'(addr_counter_max), 64'(99));
    chk("t5_new_inter", 64'(inter_counter_max), 64'(7));
    wait_to(s + 16);
    loc_tlast_transmitted = 4'h0;
    wait_to(s + 18);

    // T6: asynchronous reset mid-OPE
    s = cyc;
    set_cfg(8, 2, 1, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_to(s + 5);
    chk("t6_pre_ope", 64'(glo_fsm_state), 64'(2));
    #2 rst = 1'b1;
    #1;
    chk("t6_async_state", 64'(glo_fsm_state), 64'(0));
    chk("t6_async_busy", 64'(busy), 64'(0));
    chk("t6_async_addr", 64'(addr_counter_max), 64'(0));
    chk("t6_async_pulses", 64'({done, err}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_stays_idle", 64'(glo_fsm_state), 64'(0));

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
